// File: rtl/decoder_scan.sv
// Registered binary-to-line decoder: one-hot / thermometer direct decode,
// free-running scan and one-shot sweep with busy/done status.

module decoder_scan_lane #(
  parameter int SEL_W = 2,
  parameter int LANE  = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             thermo,
  input  logic             active,
  output logic             line
);
  always_comb begin
    line = 1'b0;
    if (active) begin
      if (thermo) line = (int'(sel) >= LANE);
      else        line = (int'(sel) == LANE);
    end
  end
endmodule

module decoder_scan #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      a,
  input  logic                  start,
  output logic [(1<<SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  done
);
  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = '1;

  localparam logic [1:0] M_ONEHOT = 2'b00;
  localparam logic [1:0] M_THERMO = 2'b01;
  localparam logic [1:0] M_SCAN   = 2'b10;
  localparam logic [1:0] M_SWEEP  = 2'b11;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [OUT_W-1:0]  y_q, y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SEL_W-1:0]  dec_sel;
  logic              dec_thermo;
  logic              dec_active;
  logic              mode_chg;
  logic              last_dwell;
  logic              last_idx;

  assign mode_chg   = (mode != mode_q);
  assign last_dwell = (dwell_q == DWELL_LAST);
  assign last_idx   = (idx_q == IDX_LAST);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    dwell_d    = dwell_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dec_sel    = idx_q;
    dec_thermo = 1'b0;
    dec_active = 1'b0;

    // With en low everything holds except y and done, which drop to 0.
    if (en) begin
      mode_d = mode;
      case (mode)
        M_ONEHOT, M_THERMO: begin
          state_d    = S_IDLE;
          dwell_d    = '0;
          busy_d     = 1'b0;
          idx_d      = mode_chg ? '0 : a;
          dec_sel    = a;
          dec_thermo = (mode == M_THERMO);
          dec_active = 1'b1;
        end
        M_SCAN: begin
          state_d    = S_IDLE;
          busy_d     = 1'b1;
          dec_active = 1'b1;
          if (mode_chg) begin
            idx_d   = '0;
            dwell_d = '0;
          end else if (last_dwell) begin
            idx_d   = idx_q + SEL_W'(1);
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
          dec_sel = idx_d;
        end
        default: begin
          if (mode_chg || state_q == S_IDLE) begin
            idx_d   = '0;
            dwell_d = '0;
            if (!mode_chg && start) begin
              state_d    = S_SWEEP;
              busy_d     = 1'b1;
              dec_active = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else if (last_dwell && last_idx) begin
            state_d = S_IDLE;
            idx_d   = '0;
            dwell_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            dec_active = 1'b1;
            if (last_dwell) begin
              idx_d   = idx_q + SEL_W'(1);
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + CNT_W'(1);
            end
          end
          dec_sel = idx_d;
        end
      endcase
    end
  end

  for (genvar i = 0; i < OUT_W; i++) begin : g_lane
    decoder_scan_lane #(.SEL_W(SEL_W), .LANE(i)) u_lane (
      .sel    (dec_sel),
      .thermo (dec_thermo),
      .active (dec_active),
      .line   (y_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_ONEHOT;
      idx_q   <= '0;
      dwell_q <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
